// File: rtl/immgen_pipe.sv
// immgen_pipe: pipelined immediate generator between IF/ID and decode/execute.
// Decodes the instruction immediate on the incoming word, extends it to XLEN
// and registers it with the instruction and PC behind a valid/ready handshake.
//
// Parameters:
//   XLEN  datapath width, 32 or 64
//   SKID  1 = main + skid register, ready comes straight from a flop
//         0 = single main register, o_ready = !o_valid || i_ready
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_flush              drop all buffered entries and this cycle's input
//   i_valid / o_ready    upstream handshake
//   i_ins, i_pc          instruction word and its PC
//   o_valid / i_ready    downstream handshake
//   o_imm, o_imm_type    extended immediate and type code (0 NONE .. 7 ZIMM)
//   o_ins, o_pc          registered copies of the instruction and PC
module immgen_pipe #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SKID = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_ins,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_imm_type,
  output logic [31:0]     o_ins,
  output logic [XLEN-1:0] o_pc
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] T_NONE  = 3'd0;
  localparam logic [2:0] T_I     = 3'd1;
  localparam logic [2:0] T_S     = 3'd2;
  localparam logic [2:0] T_B     = 3'd3;
  localparam logic [2:0] T_U     = 3'd4;
  localparam logic [2:0] T_J     = 3'd5;
  localparam logic [2:0] T_SHAMT = 3'd6;
  localparam logic [2:0] T_ZIMM  = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      ty;
    logic [31:0]     ins;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0] imm_c;
  logic [2:0]      type_c;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i_c;
  logic [XLEN-1:0] imm_s_c;
  logic [XLEN-1:0] imm_b_c;
  logic [XLEN-1:0] imm_u_c;
  logic [XLEN-1:0] imm_j_c;
  logic [XLEN-1:0] shamt_c;
  logic [XLEN-1:0] shamt_w_c;
  entry_t          in_c;
  entry_t          main_q;
  logic            main_valid;
  logic            accept_c;
  logic            consume_c;

  assign opcode = i_ins[6:0];
  assign funct3 = i_ins[14:12];

  // Sign-extended immediate formats; width casts of signed values extend bit 31.
  assign imm_i_c = XLEN'($signed(i_ins[31:20]));
  assign imm_s_c = XLEN'($signed({i_ins[31:25], i_ins[11:7]}));
  assign imm_b_c = XLEN'($signed({i_ins[31], i_ins[7], i_ins[30:25], i_ins[11:8], 1'b0}));
  assign imm_u_c = XLEN'($signed({i_ins[31:12], 12'b0}));
  assign imm_j_c = XLEN'($signed({i_ins[31], i_ins[19:12], i_ins[20], i_ins[30:21], 1'b0}));

  // RV64 shifts carry a 6-bit shamt; word shifts always use 5 bits.
  assign shamt_c   = (XLEN == 64) ? XLEN'(i_ins[25:20]) : XLEN'(i_ins[24:20]);
  assign shamt_w_c = XLEN'(i_ins[24:20]);

  // Immediate type and value selection by opcode/funct3.
  always_comb begin
    imm_c  = '0;
    type_c = T_NONE;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        imm_c  = imm_u_c;
        type_c = T_U;
      end
      OP_JAL: begin
        imm_c  = imm_j_c;
        type_c = T_J;
      end
      OP_BRANCH: begin
        imm_c  = imm_b_c;
        type_c = T_B;
      end
      OP_STORE: begin
        imm_c  = imm_s_c;
        type_c = T_S;
      end
      OP_LOAD, OP_JALR: begin
        imm_c  = imm_i_c;
        type_c = T_I;
      end
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          imm_c  = shamt_c;
          type_c = T_SHAMT;
        end else begin
          imm_c  = imm_i_c;
          type_c = T_I;
        end
      end
      OP_IMM32: begin
        if (XLEN == 64) begin
          if (funct3 == 3'b001 || funct3 == 3'b101) begin
            imm_c  = shamt_w_c;
            type_c = T_SHAMT;
          end else begin
            imm_c  = imm_i_c;
            type_c = T_I;
          end
        end
      end
      OP_SYSTEM: begin
        case (funct3)
          3'b001, 3'b010, 3'b011: begin
            imm_c  = XLEN'(i_ins[31:20]);
            type_c = T_I;
          end
          3'b101, 3'b110, 3'b111: begin
            imm_c  = XLEN'(i_ins[19:15]);
            type_c = T_ZIMM;
          end
          default: begin
            imm_c  = '0;
            type_c = T_NONE;
          end
        endcase
      end
      default: begin
        imm_c  = '0;
        type_c = T_NONE;
      end
    endcase
  end

  assign in_c      = {imm_c, type_c, i_ins, i_pc};
  assign accept_c  = i_valid && o_ready && !i_flush;
  assign consume_c = main_valid && i_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic   skid_valid;
      entry_t skid_q;

      // Ready depends only on the skid flop, so there is no comb path from i_ready.
      assign o_ready = !skid_valid;

      // Main/skid storage; flush beats both accept and the skid-to-main move.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          main_valid <= 1'b0;
          main_q     <= '0;
          skid_valid <= 1'b0;
          skid_q     <= '0;
        end else if (i_flush) begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end else if (consume_c && skid_valid) begin
          main_q     <= skid_q;
          skid_valid <= accept_c;
          if (accept_c) skid_q <= in_c;
        end else if (consume_c || !main_valid) begin
          main_valid <= accept_c;
          if (accept_c) main_q <= in_c;
        end else if (accept_c) begin
          skid_valid <= 1'b1;
          skid_q     <= in_c;
        end
      end
    end else begin : g_noskid
      assign o_ready = !main_valid || i_ready;

      // Single output register.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          main_valid <= 1'b0;
          main_q     <= '0;
        end else if (i_flush) begin
          main_valid <= 1'b0;
        end else if (accept_c) begin
          main_valid <= 1'b1;
          main_q     <= in_c;
        end else if (i_ready) begin
          main_valid <= 1'b0;
        end
      end
    end
  endgenerate

  assign o_valid    = main_valid;
  assign o_imm      = main_q.imm;
  assign o_imm_type = main_q.ty;
  assign o_ins      = main_q.ins;
  assign o_pc       = main_q.pc;

endmodule

// File: doc/immgen_pipe.md
# immgen_pipe

Pipelined, parametrised immediate generator for the pipelined core. It sits between the fetch/IF-ID register and the decode/execute stage. It extracts and extends the instruction immediate to XLEN bits and reports an immediate-type code. Over the single-cycle generator it adds RV64 support, OP-IMM-32 and CSR-immediate decoding, a registered valid/ready stage with optional skid buffer, and flush.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- SKID, 1: 1 = two-entry skid buffer, no combinational ready path; 0 = single register, o_ready = !o_valid || i_ready.
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_flush  input  1  discard all buffered entries and any input offered this cycle.
- i_valid  input  1  upstream instruction valid.
- o_ready  output  1  block can accept an instruction this cycle.
- i_ins  input  32  instruction word.
- i_pc  input  XLEN  instruction PC, passed through unchanged.
- o_valid  output  1  output entry valid.
- i_ready  input  1  downstream accepts the output entry.
- o_imm  output  XLEN  extended immediate.
- o_imm_type  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM.
- o_ins  output  32  registered copy of the instruction.
- o_pc  output  XLEN  registered copy of the PC.

## Operation
- Decode is combinational on i_ins. The result is captured with i_ins and i_pc when i_valid && o_ready && !i_flush.
- Immediate types by opcode:
  - LUI/AUIPC (0110111/0010111) -> U: {ins[31:12],12'b0}, sign-extended from bit 31 to XLEN.
  - JAL 1101111 -> J.
  - BRANCH 1100011 -> B.
  - STORE 0100011 -> S.
  - LOAD 0000011 and JALR 1100111 -> I.
- OP-IMM 0010011:
  - funct3 001/101 -> SHAMT, zero-extended. Field is ins[24:20] for XLEN=32 and ins[25:20] for XLEN=64.
  - Any other funct3 -> I.
- OP-IMM-32 0011011, XLEN=64 only:
  - funct3 001/101 -> SHAMT from ins[24:20].
  - Any other funct3 -> I.
  - With XLEN=32 this opcode is NONE.
- SYSTEM 1110011:
  - funct3 001/010/011 -> I, with ins[31:20] zero-extended (CSR address).
  - funct3 101/110/111 -> ZIMM, with ins[19:15] zero-extended.
  - funct3 000/100 -> NONE.
- All other opcodes -> NONE, o_imm = 0.
- I/S/B/J immediates are sign-extended from ins[31] to XLEN.
- SKID=1:
  - Storage is a main register (drives outputs) and a skid register.
  - o_ready = !skid_valid, taken from a register.
  - Accept while main is empty, or main is being consumed (i_ready) -> the entry goes to main.
  - Accept while main is full and not consumed -> the entry goes to skid.
  - Main consumed while skid is valid -> skid moves to main on the same edge; a simultaneous accept goes to skid.
- SKID=0: single main register only.
- Entries leave in acceptance order. No entry is dropped or duplicated except by flush.
- While o_valid && !i_ready, o_imm, o_imm_type, o_ins and o_pc hold stable.
- Flush:
  - i_flush clears main_valid and skid_valid at the next edge.
  - Input offered in the flush cycle is not captured.
  - Flush has priority over accept and over the skid-to-main move.

## Timing
- Latency: an instruction accepted at edge N is on the outputs with o_valid=1 after edge N. This is one cycle.
- Throughput: one instruction per cycle while i_ready=1, for both SKID settings.
- Reset (i_rst_n=0, asynchronous):
  - o_valid=0, o_imm=0, o_imm_type=0, o_ins=0, o_pc=0.
  - Internal skid_valid=0, so o_ready=1.
  - The reset state holds while reset is asserted, independent of the clock.
- Reset release: the first capture can occur at the first rising edge with i_rst_n=1.
- Reset asserted mid-stream drops all entries immediately; no partial state survives.
- Backpressure, SKID=1: with i_ready=0 the buffer holds two entries.
  - o_ready falls the cycle after skid fills.
  - o_ready returns to 1 the cycle after main is consumed and skid moves down.
- Simultaneous flush and i_ready: the consumed entry counts as delivered and buffers still clear.

## Test plan
- XLEN=32, ADDI 0xFFF00093, i_ready=1 -> one cycle later o_valid=1, o_imm=0xFFFFFFFF, type 1. BEQ 0xFE000EE3 -> o_imm=0xFFFFFFFC, type 3.
- Shifts:
  - XLEN=32, SRAI 0x40105093 -> o_imm=0x00000001, type 6.
  - XLEN=64, SRAI shamt 33 (0x42105093) -> o_imm=33, type 6.
  - XLEN=64, SRAIW 0x4010509B -> o_imm=1, type 6.
- XLEN=64: LUI 0x800000B7 -> o_imm=0xFFFFFFFF80000000, type 4. CSRRWI 0x3002D073 -> o_imm=5, type 7. CSRRW 0x30001073 -> o_imm=0x300, type 1. ECALL 0x00000073 -> o_imm=0, type 0.
- SKID=1 backpressure:
  - Stimulus: offer A, B, C back-to-back with i_ready=0 for 3 cycles, then i_ready=1.
  - Response: o_ready=0 after A and B are held; C is accepted only after release.
  - Outputs: A, B, C in order; o_imm stable during the stall.
- Flush:
  - Stimulus: two entries buffered, then i_flush=1 with i_valid=1 and instruction D.
  - Response: o_valid=0 next cycle; D is never output; o_ready=1.
- Asynchronous reset mid-stream: i_rst_n driven low between clock edges -> o_valid=0, o_imm=0, o_pc=0 immediately. First instruction after release appears one cycle after its accepting edge.
